// File: rtl/issue_queue.sv
// Issue queue: compacting, age-ordered buffer between rename and execute.
// Tracks physical source readiness and issues the oldest ready uop.
package iq_pkg;

  typedef struct packed {
    logic [7:0] rs1;
    logic       rs1_valid;
    logic [7:0] rs2;
    logic       rs2_valid;
    logic [7:0] rd;
    logic       rd_valid;
  } uop_ic_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    uop_ic_t     uop_ic;
  } uop_t;

endpackage

module issue_queue
  import iq_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int PHY_RF_DEPTH = 128,
  localparam int PRW = $clog2(PHY_RF_DEPTH),
  localparam int CW  = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  uop_t           uop_in,
  input  logic           uop_in_valid,
  output logic           uop_in_ready,
  output logic [PRW-1:0] busy_table_rd_addr1,
  output logic [PRW-1:0] busy_table_rd_addr2,
  input  logic           busy_table_rd_data1,
  input  logic           busy_table_rd_data2,
  input  logic           wb_valid,
  input  logic [PRW-1:0] wb_tag,
  output uop_t           uop_out,
  output logic           uop_out_valid,
  input  logic           uop_out_ready,
  output logic [CW-1:0]  count
);

  localparam int IW = $clog2(DEPTH);

  uop_t           ent_q [DEPTH];
  uop_t           ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] r1_q, r1_d;
  logic [DEPTH-1:0] r2_q, r2_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           sel_hit;
  logic [IW-1:0]  sel_idx;
  logic           enq;
  logic           iss;
  logic [CW-1:0]  tail;
  logic [PRW-1:0] in_t1;
  logic [PRW-1:0] in_t2;
  logic           in_r1;
  logic           in_r2;

  assign in_t1 = uop_in.uop_ic.rs1[PRW-1:0];
  assign in_t2 = uop_in.uop_ic.rs2[PRW-1:0];

  assign busy_table_rd_addr1 = in_t1;
  assign busy_table_rd_addr2 = in_t2;

  // Same-cycle writeback must bypass the stale busy-table read.
  assign in_r1 = !uop_in.uop_ic.rs1_valid
              || (in_t1 == '0)
              || !busy_table_rd_data1
              || (wb_valid && (wb_tag == in_t1));

  assign in_r2 = !uop_in.uop_ic.rs2_valid
              || (in_t2 == '0)
              || !busy_table_rd_data2
              || (wb_valid && (wb_tag == in_t2));

  assign count        = cnt_q;
  assign uop_in_ready = (cnt_q != CW'(DEPTH));
  assign enq          = uop_in_valid && uop_in_ready;
  assign iss          = sel_hit && uop_out_ready;
  assign tail         = cnt_q - CW'(iss);

  // Oldest-first select over registered ready bits.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && r1_q[i] && r2_q[i]) begin
        sel_hit = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign uop_out_valid = sel_hit;
  assign uop_out       = sel_hit ? ent_q[sel_idx] : '0;

  // Next state: compact on issue, wake up shifted entries, then append.
  always_comb begin
    ent_d = ent_q;
    vld_d = vld_q;
    r1_d  = r1_q;
    r2_d  = r2_q;
    cnt_d = cnt_q + CW'(enq) - CW'(iss);

    if (iss) begin
      for (int j = 0; j < DEPTH - 1; j++) begin
        if (j >= int'(sel_idx)) begin
          ent_d[j] = ent_q[j+1];
          vld_d[j] = vld_q[j+1];
          r1_d[j]  = r1_q[j+1];
          r2_d[j]  = r2_q[j+1];
        end
      end
      vld_d[DEPTH-1] = 1'b0;
      r1_d[DEPTH-1]  = 1'b0;
      r2_d[DEPTH-1]  = 1'b0;
    end

    if (wb_valid) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (vld_d[j]) begin
          if (ent_d[j].uop_ic.rs1[PRW-1:0] == wb_tag) r1_d[j] = 1'b1;
          if (ent_d[j].uop_ic.rs2[PRW-1:0] == wb_tag) r2_d[j] = 1'b1;
        end
      end
    end

    if (enq) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (int'(tail) == j) begin
          ent_d[j] = uop_in;
          vld_d[j] = 1'b1;
          r1_d[j]  = in_r1;
          r2_d[j]  = in_r2;
        end
      end
    end
  end

  // Control state: reset and flush empty the queue.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      vld_q <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage; contents are don't-care while the valid bit is low.
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      ent_q[j] <= ent_d[j];
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue.
// Expected issue order is queued up front and checked by a monitor.
module tb_issue_queue;
  import iq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  uop_t       uop_in;
  logic       uop_in_valid;
  logic       uop_in_ready;
  logic [6:0] ba1, ba2;
  logic       bd1, bd2;
  logic       wb_valid;
  logic [6:0] wb_tag;
  uop_t       uop_out;
  logic       uop_out_valid;
  logic       uop_out_ready;
  logic [3:0] count;

  logic [127:0] busy;
  uop_t sb [$];
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  assign bd1 = busy[ba1];
  assign bd2 = busy[ba2];

  issue_queue #(.DEPTH(8), .PHY_RF_DEPTH(128)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .uop_in              (uop_in),
    .uop_in_valid        (uop_in_valid),
    .uop_in_ready        (uop_in_ready),
    .busy_table_rd_addr1 (ba1),
    .busy_table_rd_addr2 (ba2),
    .busy_table_rd_data1 (bd1),
    .busy_table_rd_data2 (bd2),
    .wb_valid            (wb_valid),
    .wb_tag              (wb_tag),
    .uop_out             (uop_out),
    .uop_out_valid       (uop_out_valid),
    .uop_out_ready       (uop_out_ready),
    .count               (count)
  );

  function automatic uop_t mk(int pc, int rs1, bit v1, int rs2, bit v2);
    uop_t u;
    u = '0;
    u.pc = 32'(pc);
    u.inst = 32'(pc * 3 + 1);
    u.uop_ic.rs1 = 8'(rs1);
    u.uop_ic.rs1_valid = v1;
    u.uop_ic.rs2 = 8'(rs2);
    u.uop_ic.rs2_valid = v2;
    u.uop_ic.rd = 8'(pc + 40);
    u.uop_ic.rd_valid = 1'b1;
    return u;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drain();
    int n = 0;
    uop_out_ready = 1'b1;
    while (count != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain_count", 32'(count), 32'd0);
  endtask

  // Scoreboard monitor: every accepted issue must match the next expectation.
  always @(negedge clk) begin
    if (rst && !flush && uop_out_valid && uop_out_ready) begin
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL issue_unexpected: got pc %0h required none",
                 uop_out.pc);
      end else begin
        uop_t e;
        e = sb.pop_front();
        if (uop_out !== e) begin
          errs++;
          $display("FAIL issue_order: got pc %0h required pc %0h",
                   uop_out.pc, e.pc);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    busy = '0;
    wb_valid = 1'b0;
    wb_tag = '0;
    uop_out_ready = 1'b1;
    uop_in = mk(1, 3, 1, 0, 0);
    uop_in_valid = 1'b1;

    // reset held with a pending enqueue
    step();
    step();
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(uop_out_valid), 32'd0);
    chk("rst_in_ready", 32'(uop_in_ready), 32'd1);
    chk("rst_out_zero", uop_out.pc, 32'd0);

    // first enqueue, issuable next cycle
    step();
    rst = 1'b1;
    uop_in = mk('h10, 5, 1, 0, 0);
    sb.push_back(uop_in);
    step();
    uop_in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", 32'(uop_out_valid), 32'd1);
    chk("t1_rs1", 32'(uop_out.uop_ic.rs1), 32'd5);
    chk("t1_count", 32'(count), 32'd1);
    step();

    // wakeup ordering: younger ready B goes before busy A
    busy[10] = 1'b1;
    sb.push_back(mk('h21, 11, 1, 0, 0));
    sb.push_back(mk('h20, 10, 1, 0, 0));
    uop_in = mk('h20, 10, 1, 0, 0);
    uop_in_valid = 1'b1;
    step();
    uop_in = mk('h21, 11, 1, 0, 0);
    step();
    uop_in_valid = 1'b0;
    @(negedge clk);
    chk("t2_b_first", uop_out.pc, 32'h21);
    step();
    wb_valid = 1'b1;
    wb_tag = 7'd10;
    @(negedge clk);
    chk("t2_a_waiting", 32'(uop_out_valid), 32'd0);
    step();
    wb_valid = 1'b0;
    busy[10] = 1'b0;
    @(negedge clk);
    chk("t2_a_woken", uop_out.pc, 32'h20);
    step();

    // same-cycle writeback bypass at enqueue
    busy[20] = 1'b1;
    wb_valid = 1'b1;
    wb_tag = 7'd20;
    uop_in = mk('h30, 20, 1, 0, 1);
    uop_in_valid = 1'b1;
    sb.push_back(uop_in);
    step();
    wb_valid = 1'b0;
    uop_in_valid = 1'b0;
    @(negedge clk);
    chk("t3_bypass", uop_out.pc, 32'h30);
    step();
    busy[20] = 1'b0;

    // fill to full under backpressure
    uop_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      uop_in = mk('h40 + i, 0, 0, 0, 0);
      uop_in_valid = 1'b1;
      sb.push_back(uop_in);
      step();
    end
    uop_in_valid = 1'b0;
    @(negedge clk);
    chk("t4_full_count", 32'(count), 32'd8);
    chk("t4_full_ready", 32'(uop_in_ready), 32'd0);
    chk("t4_oldest", uop_out.pc, 32'h40);
    step();
    uop_in = mk('h48, 0, 0, 0, 0);
    uop_in_valid = 1'b1;
    step();
    uop_in_valid = 1'b0;
    @(negedge clk);
    chk("t4_ninth_drop", 32'(count), 32'd8);
    chk("t4_stable", uop_out.pc, 32'h40);
    step();
    uop_out_ready = 1'b1;
    step();
    uop_out_ready = 1'b0;
    @(negedge clk);
    chk("t4_after_count", 32'(count), 32'd7);
    chk("t4_after_ready", 32'(uop_in_ready), 32'd1);
    chk("t4_next", uop_out.pc, 32'h41);
    drain();

    // simultaneous enqueue and issue at count 3
    uop_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      uop_in = mk('h50 + i, 0, 0, 0, 0);
      uop_in_valid = 1'b1;
      sb.push_back(uop_in);
      step();
    end
    uop_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_count3", 32'(count), 32'd3);
    step();
    uop_out_ready = 1'b1;
    uop_in = mk('h53, 0, 0, 0, 0);
    uop_in_valid = 1'b1;
    sb.push_back(uop_in);
    step();
    uop_out_ready = 1'b0;
    uop_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_count_same", 32'(count), 32'd3);
    chk("t5_head", uop_out.pc, 32'h51);
    drain();

    // flush with five entries and a pending enqueue
    uop_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      uop_in = mk('h60 + i, 0, 0, 0, 0);
      uop_in_valid = 1'b1;
      step();
    end
    uop_in_valid = 1'b0;
    @(negedge clk);
    chk("t6_count5", 32'(count), 32'd5);
    step();
    flush = 1'b1;
    uop_in = mk('h65, 0, 0, 0, 0);
    uop_in_valid = 1'b1;
    step();
    flush = 1'b0;
    uop_in_valid = 1'b0;
    @(negedge clk);
    chk("t6_count0", 32'(count), 32'd0);
    chk("t6_out_valid", 32'(uop_out_valid), 32'd0);
    chk("t6_in_ready", 32'(uop_in_ready), 32'd1);
    uop_out_ready = 1'b1;
    step();
    step();

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
